// File: rtl/branch_join_n_if.sv
// Handshake bundle for branch_join_n: per-branch input streams, joined output
// stream, occupancy/watchdog status and the synchronous flush/clear controls.
interface branch_join_n_if #(
  parameter int N_BR  = 2,
  parameter int W     = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [N_BR-1:0]    in_valid;
  logic [N_BR-1:0]    in_ready;
  logic [N_BR*W-1:0]  in_data;
  logic               out_valid;
  logic               out_ready;
  logic [N_BR*W-1:0]  out_data;
  logic [N_BR*CW-1:0] fill;
  logic               skew_err;
  logic               clr;
  logic               err_clr;

  // Upstream/downstream/control side that drives the join.
  modport master (
    output in_valid, in_data, out_ready, clr, err_clr,
    input  in_ready, out_valid, out_data, fill, skew_err
  );

  // The join itself.
  modport slave (
    input  in_valid, in_data, out_ready, clr, err_clr,
    output in_ready, out_valid, out_data, fill, skew_err
  );
endinterface

// File: rtl/branch_join_n.sv
// N-branch stream join: one DEPTH-entry FIFO per branch, a joined beat of all
// heads whenever every branch holds data, plus a sticky branch-skew watchdog.
module branch_join_n #(
  parameter int N_BR     = 2,
  parameter int W        = 32,
  parameter int DEPTH    = 4,
  parameter int SKEW_MAX = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  branch_join_n_if.slave bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int SCW = $clog2(SKEW_MAX + 1);

  localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);
  localparam logic [SCW-1:0] SKEW_LAST = SCW'(SKEW_MAX - 1);
  localparam logic [SCW-1:0] SKEW_TOP  = SCW'(SKEW_MAX);

  logic [W-1:0]    mem    [N_BR][DEPTH];
  logic [AW-1:0]   wr_ptr [N_BR];
  logic [AW-1:0]   rd_ptr [N_BR];
  logic [CW-1:0]   cnt    [N_BR];

  logic [N_BR-1:0] push;
  logic [N_BR-1:0] nonempty;
  logic            all_ne;
  logic            pop;
  logic            skewed;
  logic            skew_set;
  logic [SCW-1:0]  wd_cnt;
  logic            skew_err_q;

  // Handshake and status decode; everything here depends only on registered
  // state except push/pop, so in_ready never sees out_ready.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment so no path can leave it unassigned and infer a latch.
    push          = '0;
    nonempty      = '0;
    bus.in_ready  = '0;
    bus.out_data  = '0;
    bus.fill      = '0;
    for (int i = 0; i < N_BR; i++) begin
      nonempty[i]                 = (cnt[i] != '0);
      bus.in_ready[i]             = (cnt[i] != FULL_CNT);
      push[i]                     = bus.in_valid[i] && (cnt[i] != FULL_CNT);
      bus.out_data[i*W +: W]      = mem[i][rd_ptr[i]];
      bus.fill[i*CW +: CW]        = cnt[i];
    end
    all_ne        = &nonempty;
    bus.out_valid = all_ne;
    pop           = all_ne && bus.out_ready;
    skewed        = (|nonempty) && !all_ne;
    skew_set      = skewed && (wd_cnt == SKEW_LAST);
    bus.skew_err  = skew_err_q;
  end

  // Payload storage. Flush leaves contents alone: out_data is don't-care
  // while out_valid is low, and pointers are what define the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the storage array is reset because the reset state of out_data is
    // defined as zero; a pure data RAM would normally be left unreset.
    if (!rst_n) begin
      for (int i = 0; i < N_BR; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem[i][j] <= '0;
        end
      end
    end else if (!bus.clr) begin
      for (int i = 0; i < N_BR; i++) begin
        if (push[i]) mem[i][wr_ptr[i]] <= bus.in_data[i*W +: W];
      end
    end
  end

  // Pointers wrap naturally at AW bits because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      for (int i = 0; i < N_BR; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else if (bus.clr) begin
      for (int i = 0; i < N_BR; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < N_BR; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop)     rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], pop})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Skew watchdog: counts consecutive cycles where some but not all branches
  // hold data. The flag sets once on the SKEW_MAX-th such cycle and a set in
  // the same cycle overrides err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt     <= '0;
      skew_err_q <= 1'b0;
    end else if (bus.clr) begin
      wd_cnt     <= '0;
      skew_err_q <= 1'b0;
    end else begin
      if (!skewed)                wd_cnt <= '0;
      else if (wd_cnt != SKEW_TOP) wd_cnt <= wd_cnt + SCW'(1);

      if (skew_set)          skew_err_q <= 1'b1;
      else if (bus.err_clr)  skew_err_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_branch_join_n.sv
// Bench for branch_join_n: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_branch_join_n;
  localparam int N_BR     = 2;
  localparam int W        = 32;
  localparam int DEPTH    = 4;
  localparam int SKEW_MAX = 8;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  branch_join_n_if #(.N_BR(N_BR), .W(W), .DEPTH(DEPTH)) bus ();

  branch_join_n #(
    .N_BR(N_BR), .W(W), .DEPTH(DEPTH), .SKEW_MAX(SKEW_MAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each branch is a plain queue; the watchdog is a run length of skewed cycles.
  logic [W-1:0]    mq [N_BR][$];
  int              skew_run;
  bit              m_err;
  bit              any_ne, all_ne, skw, set_now;
  bit [N_BR-1:0]   acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bus.clr) begin
      for (int i = 0; i < N_BR; i++) mq[i].delete();
      skew_run = 0;
      m_err    = 0;
    end else begin
      any_ne = 0;
      all_ne = 1;
      for (int i = 0; i < N_BR; i++) begin
        if (mq[i].size() != 0) any_ne = 1;
        else                   all_ne = 0;
        acc[i] = bus.in_valid[i] && (mq[i].size() < DEPTH);
      end
      skw     = any_ne && !all_ne;
      set_now = 0;
      if (skw) begin
        skew_run++;
        if (skew_run == SKEW_MAX) set_now = 1;
      end else begin
        skew_run = 0;
      end
      if (set_now)          m_err = 1;
      else if (bus.err_clr) m_err = 0;
      if (all_ne && bus.out_ready)
        for (int i = 0; i < N_BR; i++) void'(mq[i].pop_front());
      for (int i = 0; i < N_BR; i++)
        if (acc[i]) mq[i].push_back(bus.in_data[i*W +: W]);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  logic [N_BR-1:0]    e_ready;
  logic [N_BR*CW-1:0] e_fill;
  logic [N_BR*W-1:0]  e_data;
  logic               e_valid;

  always @(negedge clk) begin
    e_valid = 1'b1;
    e_data  = '0;
    for (int i = 0; i < N_BR; i++) begin
      e_ready[i]          = (mq[i].size() != DEPTH);
      e_fill[i*CW +: CW]  = CW'(mq[i].size());
      if (mq[i].size() == 0) e_valid = 1'b0;
      else                   e_data[i*W +: W] = mq[i][0];
    end
    check("model in_ready",  64'(bus.in_ready),  64'(e_ready));
    check("model fill",      64'(bus.fill),      64'(e_fill));
    check("model out_valid", 64'(bus.out_valid), 64'(e_valid));
    check("model skew_err",  64'(bus.skew_err),  64'(m_err));
    if (e_valid) check("model out_data", 64'(bus.out_data), 64'(e_data));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] d1, input logic [31:0] d0);
    bus.in_valid = v;
    bus.in_data  = {d1, d0};
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, " in_ready"},  64'(bus.in_ready),  64'h3);
    check({tag, " fill"},      64'(bus.fill),      64'h0);
    check({tag, " skew_err"},  64'(bus.skew_err),  64'd0);
    check({tag, " out_data"},  64'(bus.out_data),  64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.clr       = 1'b0;
    bus.err_clr   = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Scenario 1: br0 at edge 0, br1 at edge 3 -> joined beat after edge 3.
    drive(2'b01, 32'h0, 32'h0001_0000);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    check("s1 valid after e0", 64'(bus.out_valid), 64'd0);
    tick();
    check("s1 valid after e1", 64'(bus.out_valid), 64'd0);
    tick();
    check("s1 valid after e2", 64'(bus.out_valid), 64'd0);
    drive(2'b10, 32'h0002_0000, 32'h0);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    check("s1 valid after e3", 64'(bus.out_valid), 64'd1);
    check("s1 data", 64'(bus.out_data), 64'h0002_0000_0001_0000);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("s1 fill after pop", 64'(bus.fill), 64'h0);

    // Scenario 2: fill to DEPTH with output stalled, fifth push held off.
    for (int j = 0; j < 5; j++) begin
      drive(2'b11, 32'h0000_00B0 + 32'(j), 32'h0000_00A0 + 32'(j));
      tick();
      if (j == 3) begin
        check("s2 in_ready after 4", 64'(bus.in_ready), 64'h0);
        check("s2 fill after 4",     64'(bus.fill),     64'h24);
      end
    end
    drive(2'b00, 32'h0, 32'h0);
    check("s2 fill after 5", 64'(bus.fill), 64'h24);
    bus.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      check("s2 beat data", 64'(bus.out_data),
            {32'h0000_00B0 + 32'(j), 32'h0000_00A0 + 32'(j)});
      tick();
    end
    bus.out_ready = 1'b0;
    check("s2 drained", 64'(bus.out_valid), 64'd0);

    // Scenario 3: one-sided skew sets skew_err after exactly SKEW_MAX edges.
    drive(2'b01, 32'h0, 32'h0000_0011);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    check("s3 err after k", 64'(bus.skew_err), 64'd0);
    for (int e = 1; e < 8; e++) begin
      tick();
      check("s3 err before k+8", 64'(bus.skew_err), 64'd0);
    end
    tick();
    check("s3 err at k+8", 64'(bus.skew_err), 64'd1);
    repeat (3) tick();
    check("s3 err sticky", 64'(bus.skew_err), 64'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check("s3 err cleared", 64'(bus.skew_err), 64'd0);
    drive(2'b10, 32'h0000_0022, 32'h0);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    check("s3 late join data", 64'(bus.out_data), 64'h0000_0022_0000_0011);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Scenario 4: push and pop together at fill 1 keeps fill, advances data.
    drive(2'b11, 32'h0000_0002, 32'h0000_0001);
    tick();
    drive(2'b11, 32'h0000_0004, 32'h0000_0003);
    bus.out_ready = 1'b1;
    tick();
    drive(2'b00, 32'h0, 32'h0);
    bus.out_ready = 1'b0;
    check("s4 fill", 64'(bus.fill), 64'h09);
    check("s4 data", 64'(bus.out_data), 64'h0000_0004_0000_0003);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Scenario 5: clr with fill 3/2 and skew_err set; inputs that cycle ignored.
    for (int j = 0; j < 3; j++) begin
      drive(2'b01, 32'h0, 32'h0000_0031 + 32'(j));
      tick();
    end
    drive(2'b00, 32'h0, 32'h0);
    for (int c = 0; c < 20 && !bus.skew_err; c++) tick();
    check("s5 err set", 64'(bus.skew_err), 64'd1);
    drive(2'b10, 32'h0000_0041, 32'h0);
    tick();
    drive(2'b10, 32'h0000_0042, 32'h0);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    check("s5 fill 3/2", 64'(bus.fill), 64'h13);
    bus.clr       = 1'b1;
    bus.out_ready = 1'b1;
    drive(2'b11, 32'h0000_00EE, 32'h0000_00DD);
    tick();
    bus.clr       = 1'b0;
    bus.out_ready = 1'b0;
    drive(2'b00, 32'h0, 32'h0);
    check("s5 fill", 64'(bus.fill), 64'h0);
    check("s5 out_valid", 64'(bus.out_valid), 64'd0);
    check("s5 in_ready", 64'(bus.in_ready), 64'h3);
    check("s5 skew_err", 64'(bus.skew_err), 64'd0);

    // Scenario 6: asynchronous reset mid-stream, then a normal push.
    drive(2'b11, 32'h0000_0062, 32'h0000_0061);
    tick();
    tick();
    drive(2'b00, 32'h0, 32'h0);
    check("s6 fill 2/2", 64'(bus.fill), 64'h12);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("s6 async");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(2'b11, 32'h0000_0066, 32'h0000_0055);
    tick();
    drive(2'b00, 32'h0, 32'h0);
    check("s6 post-reset valid", 64'(bus.out_valid), 64'd1);
    check("s6 post-reset data", 64'(bus.out_data), 64'h0000_0066_0000_0055);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
